// File: rtl/wgt_feeder_pkg.sv
// -----------------------------------------------------------------------------
// wgt_feeder_pkg
// Shared constants and FSM encoding for the weight feeder.
//   WGT_W : width of one signed weight word
//   KSIZE : weights per kernel row, equal to the weight shift-buffer depth
//   state_e : feeder FSM states
// -----------------------------------------------------------------------------
package wgt_feeder_pkg;

  localparam int WGT_W = 8;
  localparam int KSIZE = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_NEXT = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/wgt_feeder_if.sv
// -----------------------------------------------------------------------------
// wgt_feeder_if
// Bundles the weight SRAM read port and the weight shift-buffer port.
//   mem_en / mem_addr : SRAM read request (feeder -> SRAM)
//   mem_rdata         : SRAM read data, valid the cycle after mem_en
//   wgt_input         : weight word presented to the shift buffer
//   wgt_read          : wgt_input valid
//   stall             : array stall; no word is consumed while high
// master = feeder side, slave = SRAM / shift-buffer side.
// -----------------------------------------------------------------------------
interface wgt_feeder_if #(
  parameter int ADDR_W = 10
);
  import wgt_feeder_pkg::*;

  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic signed [WGT_W-1:0] mem_rdata;
  logic signed [WGT_W-1:0] wgt_input;
  logic                    wgt_read;
  logic                    stall;

  modport master (
    output mem_en, mem_addr, wgt_input, wgt_read,
    input  mem_rdata, stall
  );

  modport slave (
    input  mem_en, mem_addr, wgt_input, wgt_read,
    output mem_rdata, stall
  );

endinterface

// File: rtl/wgt_feeder_skid_fifo.sv
// -----------------------------------------------------------------------------
// wgt_feeder_skid_fifo
// Two-entry staging FIFO: a head register that drives the consumer plus a
// skid register that catches a word arriving while the head cannot drain.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i this cycle
//   pop_i      : consume the head entry this cycle (ignored when empty)
//   din_i      : incoming word
//   head_o     : oldest entry
//   count_o    : occupancy 0..2
//   full_o     : occupancy == 2
//   empty_o    : occupancy == 0
// -----------------------------------------------------------------------------
module wgt_feeder_skid_fifo #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic signed [W-1:0] din_i,
  output logic signed [W-1:0] head_o,
  output logic [1:0]          count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic signed [W-1:0] head_q, head_d;
  logic signed [W-1:0] skid_q, skid_d;
  logic [1:0]          count_q, count_d;
  logic                do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    unique case ({push_i, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 skid_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = skid_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Pop and fill together: occupancy is unchanged, order is preserved.
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = skid_q;
          skid_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the two data entries are reset along with the count because the
  // head drives wgt_input directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/wgt_feeder.sv
// -----------------------------------------------------------------------------
// wgt_feeder
// Streams signed weights linearly out of the weight SRAM (one-cycle read
// latency) into the weight shift buffer, one row of KSIZE words at a time,
// waiting for the array controller's next between rows.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, latches base_addr/num_rows (IDLE only)
//   base_addr  : first weight address
//   num_rows   : rows to stream; 0 finishes immediately
//   next       : permission to stream the following row
//   row_done   : pulse after the last word of a row is consumed
//   busy       : job in progress
//   done       : pulse after the final row is consumed
//   bus        : SRAM read port + shift-buffer port (master side)
// -----------------------------------------------------------------------------
module wgt_feeder
  import wgt_feeder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int KSIZE  = wgt_feeder_pkg::KSIZE,
  parameter int ROWS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              next,
  output logic              row_done,
  output logic              busy,
  output logic              done,
  wgt_feeder_if.master      bus
);

  localparam int                CNT_W  = $clog2(KSIZE + 1);
  localparam logic [CNT_W-1:0]  K_ALL  = CNT_W'(KSIZE);
  localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(KSIZE - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    issue_q, issue_d;   // reads issued for this row
  logic [CNT_W-1:0]    popc_q, popc_d;     // words consumed for this row
  logic [ROWS_W-1:0]   row_q, row_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic                inflight_q;
  logic                row_done_q, row_done_d;
  logic                done_q, done_d;

  logic signed [WGT_W-1:0] fifo_head;
  logic [1:0]              fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    pop, mem_en;
  logic [2:0]              occ_after;

  assign pop = !fifo_empty && !bus.stall;

  // Occupancy the FIFO will have once this cycle's pop and the in-flight word
  // settle. A new read is allowed only if that leaves room for its data, so a
  // word returning during a stall always has the skid entry free.
  assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_en    = (state_q == STREAM) && (issue_q < K_ALL) && (occ_after < 3'd2);

  wgt_feeder_skid_fifo #(.W(WGT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (bus.mem_rdata),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    popc_d     = popc_q;
    row_d      = row_q;
    rows_d     = rows_q;
    row_done_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rows_d  = num_rows;
          row_d   = '0;
          issue_d = '0;
          popc_d  = '0;
          if (num_rows != '0) state_d = STREAM;
          else                done_d  = 1'b1;
        end
      end
      STREAM: begin
        if (mem_en) begin
          addr_d  = addr_q + 1'b1;   // wraps modulo 2^ADDR_W
          issue_d = issue_q + 1'b1;
        end
        if (pop) begin
          popc_d = popc_q + 1'b1;
          if (popc_q == K_LAST) begin
            // All KSIZE reads were issued before the last word could arrive,
            // so clearing the issue count here never loses a read.
            row_done_d = 1'b1;
            issue_d    = '0;
            popc_d     = '0;
            if (row_q == rows_q - 1'b1) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = WAIT_NEXT;
            end
          end
        end
      end
      WAIT_NEXT: begin
        if (next) state_d = STREAM;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      popc_q     <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      inflight_q <= 1'b0;
      row_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      popc_q     <= popc_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      inflight_q <= mem_en;
      row_done_q <= row_done_d;
      done_q     <= done_d;
    end
  end

  // The credit check above must keep returning data out of a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && fifo_full && !pop));

  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = addr_q;
  assign bus.wgt_input = fifo_head;
  assign bus.wgt_read  = !fifo_empty;
  assign row_done      = row_done_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule
